// File: rtl/seq_shifter_pkg.sv
// Shared types for the iterative shifter: operation codes and FSM state encodings.
// Used by seq_shifter and shifter_step.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    SH_NOP = 2'b00,
    SH_LSL = 2'b01,
    SH_LSR = 2'b10,
    SH_ASR = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_nop(input sh_op_e op);
    return op == SH_NOP;
  endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// Combinational single-bit shift step (LSL/LSR/ASR, optional rotate).
// Rotate support is compiled in only when SEQ_SHIFTER_ROTATE_EN is defined.
module shifter_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  sh_op_e           op,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic lsl_fill;
  logic lsr_fill;

  // Bits shifted in at the vacated end: zero, or the bit shifted out when rotating
`ifdef SEQ_SHIFTER_ROTATE_EN
  assign lsl_fill = rot ? din[WIDTH-1] : 1'b0;
  assign lsr_fill = rot ? din[0]       : 1'b0;
`else
  assign lsl_fill = 1'b0;
  assign lsr_fill = 1'b0;
`endif

  always_comb begin
    dout = din;
    case (op)
      SH_LSL:  dout = {din[WIDTH-2:0], lsl_fill};
      SH_LSR:  dout = {lsr_fill, din[WIDTH-1:1]};
      SH_ASR:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Iterative multi-bit shifter: one 1-bit step per clock under a start/busy/done handshake.
// Define SEQ_SHIFTER_ROTATE_EN to add the rot port and rotate-left/right behaviour.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] in,
`ifdef SEQ_SHIFTER_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sout_q, sout_d;
  logic [AMT_W-1:0] count_q, count_d;
  sh_op_e           op_q, op_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] step_out;
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic             rot_q, rot_d;
`endif

  shifter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op   (op_q),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rot  (rot_q),
`endif
    .din  (sout_q),
    .dout (step_out)
  );

  // Operands are only sampled on the accept edge; SHIFT ignores start entirely
  always_comb begin
    state_d = state_q;
    sout_d  = sout_q;
    count_d = count_q;
    op_d    = op_q;
`ifdef SEQ_SHIFTER_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      ST_SHIFT: begin
        sout_d  = step_out;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        if (start) begin
          sout_d  = in;
          op_d    = sh_op_e'(op);
          count_d = amt;
`ifdef SEQ_SHIFTER_ROTATE_EN
          rot_d   = rot;
`endif
          state_d = (amt != '0 && !is_nop(sh_op_e'(op))) ? ST_SHIFT : ST_DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sout_q  <= '0;
      count_q <= '0;
      op_q    <= SH_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sout_q  <= sout_d;
      count_q <= count_d;
      op_q    <= op_d;
      busy_q  <= (state_d == ST_SHIFT);
      done_q  <= (state_d == ST_DONE);
`ifdef SEQ_SHIFTER_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed scenarios plus randomized operations
// checked against a whole-operation reference model.
module tb_seq_shifter;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;
  localparam int TIMEOUT = 100;

  logic             clk;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] in;
  logic             rot_drv;
  logic [WIDTH-1:0] sout;
  logic             busy;
  logic             done;

  int n_checks;
  int n_fail;

  seq_shifter #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .amt   (amt),
    .in    (in),
`ifdef SEQ_SHIFTER_ROTATE_EN
    .rot   (rot_drv),
`endif
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole result computed in one go from the operation definition
  function automatic logic [WIDTH-1:0] model(input logic [1:0] m_op, input int m_amt,
                                             input logic [WIDTH-1:0] d, input logic m_rot);
    logic [WIDTH-1:0] r;
    case (m_op)
      2'b01:   r = (m_rot && m_amt != 0) ? ((d << m_amt) | (d >> (WIDTH - m_amt))) : (d << m_amt);
      2'b10:   r = (m_rot && m_amt != 0) ? ((d >> m_amt) | (d << (WIDTH - m_amt))) : (d >> m_amt);
      2'b11:   r = WIDTH'($signed(d) >>> m_amt);
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int model_latency(input logic [1:0] m_op, input int m_amt);
    return (m_op == 2'b00 || m_amt == 0) ? 1 : m_amt + 1;
  endfunction

  // Caller is at a negedge. Accepts on the next posedge, scrambles inputs afterwards,
  // returns at the negedge of the done cycle (or on timeout).
  task automatic run_op(input logic [1:0] t_op, input int t_amt, input logic [WIDTH-1:0] t_in,
                        input logic t_rot, output int latency, output int busy_cycles,
                        output logic [WIDTH-1:0] result, output bit timed_out);
    int cycles;
    start   = 1'b1;
    op      = t_op;
    amt     = AMT_W'(t_amt);
    in      = t_in;
    rot_drv = t_rot;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    op      = 2'($urandom);
    amt     = AMT_W'($urandom);
    in      = WIDTH'($urandom);
    rot_drv = ~t_rot;
    cycles = 1;
    busy_cycles = 0;
    timed_out = 1'b0;
    while (!done && cycles < TIMEOUT) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    if (!done) timed_out = 1'b1;
    rot_drv = t_rot;
    latency = cycles;
    result = sout;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    amt = '0;
    in = '0;
    rot_drv = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (sout !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: sout=%h busy=%b done=%b, expected 0000/0/0", sout, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsl_single();
    int lat, bc;
    logic [WIDTH-1:0] res;
    bit to;
    run_op(2'b01, 1, 16'hF0CF, 1'b0, lat, bc, res, to);
    n_checks++;
    if (to || lat !== 2) begin
      n_fail++;
      $display("[TB] FAIL lsl1_latency: got %0d (timeout=%0d), expected 2", lat, to);
    end
    n_checks++;
    if (res !== 16'hE19E) begin
      n_fail++;
      $display("[TB] FAIL lsl1_result: got %h, expected e19e", res);
    end
    n_checks++;
    if (bc !== 1) begin
      n_fail++;
      $display("[TB] FAIL lsl1_busy_cycles: got %0d, expected 1", bc);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || sout !== 16'hE19E) begin
      n_fail++;
      $display("[TB] FAIL done_one_cycle: done=%b sout=%h, expected 0/e19e", done, sout);
    end
  endtask

  task automatic test_asr_lsr();
    int lat, bc;
    logic [WIDTH-1:0] res;
    bit to;
    run_op(2'b11, 4, 16'hF0CF, 1'b0, lat, bc, res, to);
    n_checks++;
    if (to || lat !== 5 || res !== 16'hFF0C) begin
      n_fail++;
      $display("[TB] FAIL asr4: latency=%0d sout=%h, expected 5/ff0c", lat, res);
    end
    @(negedge clk);
    run_op(2'b10, 4, 16'hF0CF, 1'b0, lat, bc, res, to);
    n_checks++;
    if (to || lat !== 5 || res !== 16'h0F0C) begin
      n_fail++;
      $display("[TB] FAIL lsr4: latency=%0d sout=%h, expected 5/0f0c", lat, res);
    end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    int lat, bc;
    logic [WIDTH-1:0] res;
    bit to;
    run_op(2'b10, 15, 16'h8000, 1'b0, lat, bc, res, to);
    n_checks++;
    if (to || lat !== 16 || bc !== 15 || res !== 16'h0001) begin
      n_fail++;
      $display("[TB] FAIL lsr15: latency=%0d busy=%0d sout=%h, expected 16/15/0001", lat, bc, res);
    end
    @(negedge clk);
    run_op(2'b11, 15, 16'h8000, 1'b0, lat, bc, res, to);
    n_checks++;
    if (to || res !== 16'hFFFF) begin
      n_fail++;
      $display("[TB] FAIL asr15_saturate: sout=%h, expected ffff", res);
    end
    @(negedge clk);
    run_op(2'b01, 0, 16'hA5C3, 1'b0, lat, bc, res, to);
    n_checks++;
    if (to || lat !== 1 || bc !== 0 || res !== 16'hA5C3) begin
      n_fail++;
      $display("[TB] FAIL amt0: latency=%0d busy=%0d sout=%h, expected 1/0/a5c3", lat, bc, res);
    end
    @(negedge clk);
    run_op(2'b00, 9, 16'h5A3C, 1'b0, lat, bc, res, to);
    n_checks++;
    if (to || lat !== 1 || bc !== 0 || res !== 16'h5A3C) begin
      n_fail++;
      $display("[TB] FAIL nop: latency=%0d busy=%0d sout=%h, expected 1/0/5a3c", lat, bc, res);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cycles;
    int lat, bc;
    logic [WIDTH-1:0] res;
    bit to;
    start = 1'b1;
    op = 2'b01;
    amt = AMT_W'(8);
    in = 16'hF0CF;
    rot_drv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < TIMEOUT) begin
      if (cycles == 3) begin
        start = 1'b1;
        in = 16'h1234;
        op = 2'b10;
        amt = AMT_W'(2);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    n_checks++;
    if (!done || cycles !== 9 || sout !== 16'hCF00) begin
      n_fail++;
      $display("[TB] FAIL busy_start_ignored: cycles=%0d done=%b sout=%h, expected 9/1/cf00",
               cycles, done, sout);
    end
    run_op(2'b11, 4, 16'hF0CF, 1'b0, lat, bc, res, to);
    n_checks++;
    if (to || lat !== 5 || res !== 16'hFF0C) begin
      n_fail++;
      $display("[TB] FAIL back_to_back: latency=%0d sout=%h, expected 5/ff0c", lat, res);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    int seen_done;
    int lat, bc;
    logic [WIDTH-1:0] res;
    bit to;
    start = 1'b1;
    op = 2'b01;
    amt = AMT_W'(10);
    in = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_busy: busy=%b, expected 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (sout !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: sout=%h busy=%b done=%b, expected 0000/0/0", sout, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("[TB] FAIL no_done_after_abort: active cycles=%0d, expected 0", seen_done);
    end
    run_op(2'b10, 3, 16'h8001, 1'b0, lat, bc, res, to);
    n_checks++;
    if (to || lat !== 4 || res !== 16'h1000) begin
      n_fail++;
      $display("[TB] FAIL start_after_reset: latency=%0d sout=%h, expected 4/1000", lat, res);
    end
    @(negedge clk);
  endtask

`ifdef SEQ_SHIFTER_ROTATE_EN
  task automatic test_rotate();
    int lat, bc;
    logic [WIDTH-1:0] res;
    bit to;
    run_op(2'b01, 4, 16'hF0CF, 1'b1, lat, bc, res, to);
    n_checks++;
    if (to || res !== 16'h0CFF) begin
      n_fail++;
      $display("[TB] FAIL rotl4: sout=%h, expected 0cff", res);
    end
    @(negedge clk);
    run_op(2'b10, 4, 16'hF0CF, 1'b1, lat, bc, res, to);
    n_checks++;
    if (to || res !== 16'hFF0C) begin
      n_fail++;
      $display("[TB] FAIL rotr4: sout=%h, expected ff0c", res);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    int lat, bc, r_amt;
    logic [1:0] r_op;
    logic [WIDTH-1:0] r_in, res, exp_res;
    logic r_rot;
    bit to;
    for (int i = 0; i < 40; i++) begin
      r_op  = 2'($urandom);
      r_amt = int'($urandom_range(0, 15));
      r_in  = WIDTH'($urandom);
`ifdef SEQ_SHIFTER_ROTATE_EN
      r_rot = 1'($urandom);
`else
      r_rot = 1'b0;
`endif
      exp_res = model(r_op, r_amt, r_in, r_rot);
      run_op(r_op, r_amt, r_in, r_rot, lat, bc, res, to);
      n_checks++;
      if (to || res !== exp_res || lat !== model_latency(r_op, r_amt) || bc !== lat - 1) begin
        n_fail++;
        $display("[TB] FAIL random_%0d: op=%0d amt=%0d in=%h rot=%b got sout=%h lat=%0d busy=%0d, expected sout=%h lat=%0d",
                 i, r_op, r_amt, r_in, r_rot, res, lat, bc, exp_res, model_latency(r_op, r_amt));
      end
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_lsl_single();
    test_asr_lsr();
    test_boundary();
    test_back_to_back();
    test_reset_mid_shift();
`ifdef SEQ_SHIFTER_ROTATE_EN
    test_rotate();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
